// File: rtl/uart_duplex.sv
// rtl/uart_duplex.sv - full-duplex UART: baud generator, FWFT TX/RX FIFOs, TX/RX framers, sticky error flags
// Optional parity bit after the data bits is compiled in by defining UART_DUPLEX_PARITY_EN.

module uart_duplex_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] r_data,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          wr_en, rd_en;

  // a full FIFO still takes a write in the cycle a read frees a slot
  assign rd_en = rd & ~empty_q;
  assign wr_en = wr & (~full_q | rd_en);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
    if (wr_en && !rd_en) begin
      empty_d = 1'b0;
      full_d  = (wptr_d == rptr_q);
    end else if (rd_en && !wr_en) begin
      full_d  = 1'b0;
      empty_d = (rptr_d == wptr_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= w_data;
  end

  assign r_data = mem_q[rptr_q];
  assign full   = full_q;
  assign empty  = empty_q;
endmodule

module uart_duplex #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR_BIT = 11,
  parameter int FIFO_AW  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic                par_odd,
  output logic                tx,
  input  logic                wr_uart,
  input  logic [DBIT-1:0]     w_data,
  output logic                tx_full,
  output logic                tx_empty,
  input  logic                rx,
  input  logic                rd_uart,
  output logic [DBIT-1:0]     r_data,
  output logic                rx_full,
  output logic                rx_empty,
  output logic                frame_err,
  output logic                parity_err,
  output logic                overrun_err,
  input  logic                clr_err
);
`ifdef UART_DUPLEX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  logic [DVSR_BIT-1:0] cnt_q, cnt_d;
  logic                tick;
  logic [DBIT-1:0]     tx_head;
  logic                tx_pop, rx_push;

  state_t          tx_state_q, tx_state_d;
  logic [4:0]      tx_s_q, tx_s_d;
  logic [2:0]      tx_n_q, tx_n_d;
  logic [DBIT-1:0] tx_b_q, tx_b_d;

  state_t          rx_state_q, rx_state_d;
  logic [4:0]      rx_s_q, rx_s_d;
  logic [2:0]      rx_n_q, rx_n_d;
  logic [DBIT-1:0] rx_b_q, rx_b_d;
  logic [1:0]      sync_q, sync_d;
  logic            rx_line, rx_done, push_req;
  logic            frame_set, par_set, over_set;
  logic            frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic            overrun_err_q, overrun_err_d;

`ifdef UART_DUPLEX_PARITY_EN
  logic tx_par_q, tx_par_d, rx_par_q, rx_par_d;
`else
  logic unused_par_odd;
  assign unused_par_odd = par_odd;
`endif

  // free-running oversample tick; dvsr is compared live
  assign tick  = (cnt_q == dvsr);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  uart_duplex_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr(wr_uart), .rd(tx_pop), .w_data(w_data),
    .r_data(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_duplex_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr(rx_push), .rd(rd_uart), .w_data(rx_b_q),
    .r_data(r_data), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      tx_state_q <= ST_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
`ifdef UART_DUPLEX_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
`ifdef UART_DUPLEX_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // the head word stays in the FIFO until its frame has been fully sent
  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
`ifdef UART_DUPLEX_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      ST_IDLE: if (!tx_empty) begin
        tx_state_d = ST_START;
        tx_s_d     = '0;
        tx_b_d     = tx_head;
`ifdef UART_DUPLEX_PARITY_EN
        tx_par_d   = (^tx_head) ^ par_odd;
`endif
      end
      ST_START: if (tick) begin
        if (tx_s_q == 5'd15) begin
          tx_state_d = ST_DATA;
          tx_s_d     = '0;
          tx_n_d     = '0;
        end else tx_s_d = tx_s_q + 5'd1;
      end
      ST_DATA: if (tick) begin
        if (tx_s_q == 5'd15) begin
          tx_s_d = '0;
          tx_b_d = tx_b_q >> 1;
          if (tx_n_q == 3'(DBIT - 1)) begin
`ifdef UART_DUPLEX_PARITY_EN
            tx_state_d = ST_PARITY;
`else
            tx_state_d = ST_STOP;
`endif
          end else tx_n_d = tx_n_q + 3'd1;
        end else tx_s_d = tx_s_q + 5'd1;
      end
`ifdef UART_DUPLEX_PARITY_EN
      ST_PARITY: if (tick) begin
        if (tx_s_q == 5'd15) begin
          tx_state_d = ST_STOP;
          tx_s_d     = '0;
        end else tx_s_d = tx_s_q + 5'd1;
      end
`endif
      ST_STOP: if (tick) begin
        if (tx_s_q == 5'(SB_TICK - 1)) tx_state_d = ST_IDLE;
        else tx_s_d = tx_s_q + 5'd1;
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx     = 1'b1;
    tx_pop = 1'b0;
    case (tx_state_q)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = tx_b_q[0];
`ifdef UART_DUPLEX_PARITY_EN
      ST_PARITY: tx = tx_par_q;
`endif
      ST_STOP:   tx_pop = tick && (tx_s_q == 5'(SB_TICK - 1));
      default:   tx = 1'b1;
    endcase
  end

  assign sync_d  = {sync_q[0], rx};
  assign rx_line = sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q        <= 2'b11;
      rx_state_q    <= ST_IDLE;
      rx_s_q        <= '0;
      rx_n_q        <= '0;
      rx_b_q        <= '0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_DUPLEX_PARITY_EN
      rx_par_q      <= 1'b0;
`endif
    end else begin
      sync_q        <= sync_d;
      rx_state_q    <= rx_state_d;
      rx_s_q        <= rx_s_d;
      rx_n_q        <= rx_n_d;
      rx_b_q        <= rx_b_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_DUPLEX_PARITY_EN
      rx_par_q      <= rx_par_d;
`endif
    end
  end

  // 7 ticks into the start bit lines every later sample up with mid-bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
`ifdef UART_DUPLEX_PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    case (rx_state_q)
      ST_IDLE: if (!rx_line) begin
        rx_state_d = ST_START;
        rx_s_d     = '0;
      end
      ST_START: if (tick) begin
        if (rx_s_q == 5'd7) begin
          rx_s_d     = '0;
          rx_n_d     = '0;
          rx_state_d = rx_line ? ST_IDLE : ST_DATA;
        end else rx_s_d = rx_s_q + 5'd1;
      end
      ST_DATA: if (tick) begin
        if (rx_s_q == 5'd15) begin
          rx_s_d = '0;
          rx_b_d = {rx_line, rx_b_q[DBIT-1:1]};
          if (rx_n_q == 3'(DBIT - 1)) begin
`ifdef UART_DUPLEX_PARITY_EN
            rx_state_d = ST_PARITY;
`else
            rx_state_d = ST_STOP;
`endif
          end else rx_n_d = rx_n_q + 3'd1;
        end else rx_s_d = rx_s_q + 5'd1;
      end
`ifdef UART_DUPLEX_PARITY_EN
      ST_PARITY: if (tick) begin
        if (rx_s_q == 5'd15) begin
          rx_s_d     = '0;
          rx_par_d   = rx_line;
          rx_state_d = ST_STOP;
        end else rx_s_d = rx_s_q + 5'd1;
      end
`endif
      ST_STOP: if (tick) begin
        if (rx_s_q == 5'(SB_TICK - 1)) rx_state_d = ST_IDLE;
        else rx_s_d = rx_s_q + 5'd1;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_done   = (rx_state_q == ST_STOP) && tick && (rx_s_q == 5'(SB_TICK - 1));
    frame_set = rx_done & ~rx_line;
    push_req  = rx_done & rx_line;
    over_set  = push_req & rx_full;
    rx_push   = push_req & ~rx_full;
`ifdef UART_DUPLEX_PARITY_EN
    par_set   = push_req & (rx_par_q ^ (^rx_b_q) ^ par_odd);
`else
    par_set   = 1'b0;
`endif
    frame_err_d   = frame_set | (frame_err_q & ~clr_err);
    parity_err_d  = par_set | (parity_err_q & ~clr_err);
    overrun_err_d = over_set | (overrun_err_q & ~clr_err);
  end

  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
endmodule

// File: tb/tb_uart_duplex.sv
// tb/tb_uart_duplex.sv - scoreboard bench for uart_duplex (loopback and injected RX frames)
`timescale 1ns/1ps
module tb_uart_duplex;
  localparam int DBIT = 8;
  localparam int SB_TICK = 16;
  localparam int DVSR_BIT = 11;
  localparam int FIFO_AW = 2;
  localparam int DEPTH = 4;
`ifdef UART_DUPLEX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 10 + P;
  localparam int BIT_CLK = 64;

  logic clk = 1'b0;
  logic reset, par_odd, wr_uart, rd_uart, clr_err, loop_en, rx_drv;
  logic [DVSR_BIT-1:0] dvsr;
  logic [DBIT-1:0] w_data, r_data;
  logic tx, tx_full, tx_empty, rx_full, rx_empty, frame_err, parity_err, overrun_err;
  wire rx;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign rx = loop_en ? tx : rx_drv;

  uart_duplex #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR_BIT(DVSR_BIT), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .par_odd(par_odd), .tx(tx),
    .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx(rx), .rd_uart(rd_uart), .r_data(r_data), .rx_full(rx_full), .rx_empty(rx_empty),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err), .clr_err(clr_err)
  );

  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (P == 1) f[9] = (^d) ^ par_odd;
    return f;
  endfunction

  task automatic pulse_rd();
    @(negedge clk); rd_uart = 1'b1;
    @(negedge clk); rd_uart = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk); wr_uart = 1'b1; w_data = d;
    @(negedge clk); wr_uart = 1'b0;
  endtask

  task automatic capture_tx(output logic [10:0] bits);
    int n;
    bits = '1;
    for (n = 0; n < 4000 && tx !== 1'b0; n++) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL tx_start_timeout: tx=%b required 0", tx);
    end else begin
      repeat (BIT_CLK/2) @(negedge clk);
      bits[0] = tx;
      for (int i = 1; i < NB; i++) begin
        repeat (BIT_CLK) @(negedge clk);
        bits[i] = tx;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input int stop_low);
    @(negedge clk); rx_drv = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < DBIT; i++) begin
      rx_drv = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (P == 1) begin
      rx_drv = pbit;
      repeat (BIT_CLK) @(negedge clk);
    end
    if (stop_low > 0) begin
      rx_drv = 1'b0;
      repeat (stop_low) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; dvsr = 11'd3; par_odd = 1'b0; wr_uart = 1'b0; rd_uart = 1'b0;
    clr_err = 1'b0; loop_en = 1'b1; rx_drv = 1'b1; w_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if ({tx_empty, tx_full, rx_empty, rx_full} !== 4'b1010) begin
      failures++; $display("FAIL reset_fifo_flags: got %b want 1010", {tx_empty, tx_full, rx_empty, rx_full}); end
    checks++; if ({frame_err, parity_err, overrun_err} !== 3'b000) begin
      failures++; $display("FAIL reset_err_flags: got %b want 000", {frame_err, parity_err, overrun_err}); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [10:0] bits;
    logic [7:0] e;
    int n;
    loop_en = 1'b1;
    @(negedge clk); wr_uart = 1'b1; w_data = 8'hA5;
    tx_exp_q.push_back(8'hA5); rx_exp_q.push_back(8'hA5);
    @(negedge clk); wr_uart = 1'b0;
    checks++; if (tx_empty !== 1'b0) begin failures++; $display("FAIL wr_tx_empty: got %b want 0", tx_empty); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL wr_tx_still_idle: got %b want 1", tx); end
    @(negedge clk);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL start_bit_edge: got %b want 0", tx); end
    capture_tx(bits);
    e = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
    checks++; if (bits !== frame_bits(e)) begin failures++; $display("FAIL loop_tx_bits: got %b want %b", bits, frame_bits(e)); end
    for (n = 0; n < 300 && rx_empty !== 1'b0; n++) @(negedge clk);
    e = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
    checks++; if (rx_empty !== 1'b0) begin failures++; $display("FAIL loop_rx_empty: got %b want 0", rx_empty); end
    checks++; if (r_data !== e) begin failures++; $display("FAIL loop_r_data: got %h want %h", r_data, e); end
    pulse_rd();
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL loop_rd_empty: got %b want 1", rx_empty); end
    for (n = 0; n < 300 && tx_empty !== 1'b1; n++) @(negedge clk);
    checks++; if (tx_empty !== 1'b1) begin failures++; $display("FAIL loop_tx_done: got %b want 1", tx_empty); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    logic [7:0] e;
    int cnt, n, lows;
    cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++; if (tx_full !== (cnt == DEPTH)) begin
        failures++; $display("FAIL b2b_tx_full_%0d: got %b want %b", i, tx_full, cnt == DEPTH); end
      wr_uart = 1'b1; w_data = 8'(i);
      if (cnt < DEPTH) begin
        tx_exp_q.push_back(8'(i)); rx_exp_q.push_back(8'(i)); cnt++;
      end
    end
    @(negedge clk); wr_uart = 1'b0;
    checks++; if (tx_full !== 1'b1) begin failures++; $display("FAIL b2b_full_after_5th: got %b want 1", tx_full); end
    for (int f = 0; f < DEPTH; f++) begin
      capture_tx(bits);
      e = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
      checks++; if (bits !== frame_bits(e)) begin failures++; $display("FAIL b2b_tx_bits_%0d: got %b want %b", f, bits, frame_bits(e)); end
    end
    for (n = 0; n < 300 && tx_empty !== 1'b1; n++) @(negedge clk);
    checks++; if (tx_empty !== 1'b1) begin failures++; $display("FAIL b2b_tx_empty: got %b want 1", tx_empty); end
    repeat (16) @(negedge clk);
    checks++; if (rx_full !== 1'b1) begin failures++; $display("FAIL b2b_rx_full: got %b want 1", rx_full); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL b2b_no_overrun: got %b want 0", overrun_err); end
    for (int f = 0; f < DEPTH; f++) begin
      e = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
      checks++; if (r_data !== e) begin failures++; $display("FAIL b2b_r_data_%0d: got %h want %h", f, r_data, e); end
      pulse_rd();
    end
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL b2b_rx_drained: got %b want 1", rx_empty); end
    lows = 0;
    repeat (800) begin @(negedge clk); if (tx === 1'b0) lows++; end
    checks++; if (lows !== 0) begin failures++; $display("FAIL b2b_fifth_sent: low cycles %0d want 0", lows); end
  endtask

  task automatic test_parity();
    logic [10:0] bits;
    logic [7:0] e;
    int n;
`ifdef UART_DUPLEX_PARITY_EN
    loop_en = 1'b1; par_odd = 1'b0;
    tx_exp_q.push_back(8'h07); rx_exp_q.push_back(8'h07);
    write_byte(8'h07);
    capture_tx(bits);
    e = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
    checks++; if (bits !== frame_bits(e)) begin failures++; $display("FAIL par_tx_bits: got %b want %b", bits, frame_bits(e)); end
    checks++; if (bits[9] !== 1'b1) begin failures++; $display("FAIL par_bit_07_even: got %b want 1", bits[9]); end
    for (n = 0; n < 300 && rx_empty !== 1'b0; n++) @(negedge clk);
    e = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
    checks++; if (r_data !== e) begin failures++; $display("FAIL par_loop_r_data: got %h want %h", r_data, e); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_good_no_err: got %b want 0", parity_err); end
    pulse_rd();
    repeat (100) @(negedge clk);
    loop_en = 1'b0; rx_drv = 1'b1;
    send_frame(8'h07, 1'b0, 0);
    repeat (8) @(negedge clk);
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_inject_err: got %b want 1", parity_err); end
`else
    loop_en = 1'b0; rx_drv = 1'b1;
    send_frame(8'h07, 1'b0, 0);
    repeat (8) @(negedge clk);
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_tied_zero: got %b want 0", parity_err); end
`endif
    checks++; if (rx_empty !== 1'b0) begin failures++; $display("FAIL par_word_pushed: got %b want 0", rx_empty); end
    checks++; if (r_data !== 8'h07) begin failures++; $display("FAIL par_r_data: got %h want 07", r_data); end
    pulse_rd();
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic test_frame_err();
    loop_en = 1'b0; rx_drv = 1'b1;
    send_frame(8'h55, (^8'h55) ^ par_odd, 40);
    repeat (100) @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL frame_err_set: got %b want 1", frame_err); end
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL frame_err_discard: got %b want 1", rx_empty); end
  endtask

  task automatic test_overrun();
    logic [7:0] d, e;
    int cnt, dropped;
    cnt = 0; dropped = 0;
    loop_en = 1'b0; rx_drv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'h11 + 8'(i);
      if (cnt < DEPTH) begin rx_exp_q.push_back(d); cnt++; end
      else dropped++;
      send_frame(d, (^d) ^ par_odd, 0);
      repeat (4) @(negedge clk);
      checks++; if (rx_full !== (cnt == DEPTH)) begin
        failures++; $display("FAIL ovr_rx_full_%0d: got %b want %b", i, rx_full, cnt == DEPTH); end
      checks++; if (overrun_err !== (dropped > 0)) begin
        failures++; $display("FAIL ovr_flag_%0d: got %b want %b", i, overrun_err, dropped > 0); end
    end
    for (int f = 0; f < DEPTH; f++) begin
      e = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
      checks++; if (r_data !== e) begin failures++; $display("FAIL ovr_r_data_%0d: got %h want %h", f, r_data, e); end
      pulse_rd();
    end
  endtask

  task automatic test_error_recovery();
    checks++; if ({frame_err, overrun_err} !== 2'b11) begin
      failures++; $display("FAIL sticky_flags: got %b want 11", {frame_err, overrun_err}); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    checks++; if ({frame_err, parity_err, overrun_err} !== 3'b000) begin
      failures++; $display("FAIL clr_err: got %b want 000", {frame_err, parity_err, overrun_err}); end
    loop_en = 1'b0;
    @(negedge clk); rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (900) @(negedge clk);
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL false_start_push: got %b want 1", rx_empty); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL false_start_ferr: got %b want 0", frame_err); end
    send_frame(8'h3C, (^8'h3C) ^ par_odd, 0);
    repeat (4) @(negedge clk);
    checks++; if (rx_empty !== 1'b0 || r_data !== 8'h3C) begin
      failures++; $display("FAIL after_false_start: empty=%b data=%h want 0/3c", rx_empty, r_data); end
    pulse_rd();
  endtask

  task automatic test_reset_mid_frame();
    loop_en = 1'b1;
    write_byte(8'h5A);
    repeat (200) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
    checks++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1) begin
      failures++; $display("FAIL rst_mid_empty: tx_empty=%b rx_empty=%b want 1/1", tx_empty, rx_empty); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (1500) @(negedge clk);
    checks++; if (rx_empty !== 1'b1 || tx !== 1'b1 || tx_empty !== 1'b1) begin
      failures++; $display("FAIL rst_mid_after: rx_empty=%b tx=%b tx_empty=%b want 1/1/1", rx_empty, tx, tx_empty); end
  endtask

  initial begin
    #600us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_overrun();
    test_error_recovery();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
